// File: rtl/ahb_uart_bridge.sv
// rtl/ahb_uart_bridge.sv - AHB register bridge to a byte-stream UART with TX/RX byte FIFOs
// Define AHB_UART_IRQ_EN to add the irq output and the CTRL[17:16] interrupt enables.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif

module ahb_uart_bridge_fifo #(
  parameter int DEPTH = 16,
  parameter int NB    = 4,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LW-1:0]   push_cnt,
  input  logic [NB*8-1:0] push_data,
  input  logic [LW-1:0]   pop_cnt,
  output logic [NB*8-1:0] peek_data,
  output logic [LW-1:0]   level
);
  localparam int PW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;

  // Callers only push into free space and only pop stored bytes, so the level never wraps.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      for (int i = 0; i < NB; i++) begin
        if (LW'(i) < push_cnt) mem[wr_ptr + PW'(i)] <= push_data[8*i +: 8];
      end
      wr_ptr <= wr_ptr + PW'(push_cnt);
      rd_ptr <= rd_ptr + PW'(pop_cnt);
      level  <= level + push_cnt - pop_cnt;
    end
  end

  always_comb begin
    peek_data = '0;
    for (int i = 0; i < NB; i++) peek_data[8*i +: 8] = mem[rd_ptr + PW'(i)];
  end
endmodule

module ahb_uart_bridge #(
  parameter int DATA_W   = 32,
  parameter int TX_DEPTH = 16,
  parameter int RX_DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       hsel,
  input  logic                       hwrite,
  input  logic [`AHB_ADDR_WIDTH-1:0] haddr,
  input  logic [DATA_W-1:0]          hwdata,
  output logic                       hready,
  output logic                       hresp,
  output logic [DATA_W-1:0]          hrdata,
  output logic                       tx_valid,
  output logic [7:0]                 tx_data,
  input  logic                       tx_ready,
  input  logic                       rx_valid,
  input  logic [7:0]                 rx_data,
  output logic                       rx_ready
`ifdef AHB_UART_IRQ_EN
  ,
  output logic                       irq
`endif
);
  localparam int NB  = DATA_W / 8;
  localparam int TLW = $clog2(TX_DEPTH + 1);
  localparam int RLW = $clog2(RX_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state, state_nxt;

  logic              rx_en, wide, nonblock;
  logic [7:0]        rx_thresh;
  logic [1:0]        ier;
  logic [1:0]        isr;
  logic [1:0]        isr_set;
  logic [DATA_W-1:0] rdata_q, rdata_nxt;
  logic              resp_q, resp_nxt;
  logic              ctrl_we, isr_we;
  logic [63:0]       wdata, rd_word;
  logic [31:0]       status_word, ctrl_word;

  logic [TLW-1:0]    tx_level, tx_free, tx_k, tx_push_cnt, tx_pop_cnt;
  logic [RLW-1:0]    rx_level, rx_k, rx_push_cnt, rx_pop_cnt;
  logic [DATA_W-1:0] tx_peek, rx_peek;

  assign wdata       = 64'(hwdata);
  assign tx_free     = TLW'(TX_DEPTH) - tx_level;
  assign tx_k        = wide ? TLW'(NB) : TLW'(1);
  assign rx_k        = wide ? RLW'(NB) : RLW'(1);
  assign status_word = {13'd0, tx_level == '0, rx_level == '0, tx_level == TLW'(TX_DEPTH),
                        8'(rx_level), 8'(tx_level)};
  assign ctrl_word   = {14'd0, ier, rx_thresh, 5'd0, nonblock, wide, rx_en};

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // ACCESS either completes (side effects fire on the edge into RESP) or holds for FIFO room/data.
  always_comb begin
    state_nxt   = state;
    rdata_nxt   = rdata_q;
    resp_nxt    = resp_q;
    tx_push_cnt = '0;
    rx_pop_cnt  = '0;
    ctrl_we     = 1'b0;
    isr_we      = 1'b0;
    rd_word     = '0;
    case (state)
      IDLE: if (hsel) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = RESP;
        resp_nxt  = 1'b0;
        case (haddr[4:2])
          3'd0: begin
            if (hwrite) begin
              if (tx_free >= tx_k) tx_push_cnt = tx_k;
              else if (nonblock)   resp_nxt = 1'b1;
              else                 state_nxt = ACCESS;
            end else begin
              if (rx_level >= rx_k) begin
                rx_pop_cnt = rx_k;
                for (int i = 0; i < NB; i++) begin
                  if (RLW'(i) < rx_k) rd_word[8*i +: 8] = rx_peek[8*i +: 8];
                end
              end else if (nonblock) begin
                resp_nxt = 1'b1;
              end else begin
                state_nxt = ACCESS;
              end
            end
          end
          3'd1: if (hwrite) resp_nxt = 1'b1; else rd_word = 64'(status_word);
          3'd2: if (hwrite) ctrl_we = 1'b1;  else rd_word = 64'(ctrl_word);
          3'd3: if (hwrite) isr_we = 1'b1;   else rd_word = {62'd0, isr};
          default: resp_nxt = 1'b1;
        endcase
        rdata_nxt = DATA_W'(rd_word);
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign isr_set[0] = (rx_thresh != 8'd0) && (32'(rx_level) >= 32'(rx_thresh));
  assign isr_set[1] = rx_valid && rx_ready && (rx_level == RLW'(RX_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_q   <= '0;
      resp_q    <= 1'b0;
      rx_en     <= 1'b0;
      wide      <= 1'b0;
      nonblock  <= 1'b0;
      rx_thresh <= 8'd0;
      isr       <= 2'b00;
    end else begin
      rdata_q <= rdata_nxt;
      resp_q  <= resp_nxt;
      if (ctrl_we) begin
        rx_en     <= wdata[0];
        wide      <= wdata[1];
        nonblock  <= wdata[2];
        rx_thresh <= wdata[15:8];
      end
      // A set event on the same edge as a write-1-to-clear wins.
      isr <= (isr & ~(isr_we ? wdata[1:0] : 2'b00)) | isr_set;
    end
  end

`ifdef AHB_UART_IRQ_EN
  always_ff @(posedge clk) begin
    if (rst)          ier <= 2'b00;
    else if (ctrl_we) ier <= wdata[17:16];
  end
  assign irq = |(isr & ier);
`else
  assign ier = 2'b00;
`endif

  assign hready = (state == RESP);
  assign hresp  = hready & resp_q;
  assign hrdata = hready ? rdata_q : '0;

  assign tx_valid    = (tx_level != '0);
  assign tx_data     = tx_valid ? tx_peek[7:0] : 8'h00;
  assign tx_pop_cnt  = TLW'(tx_valid && tx_ready);
  assign rx_ready    = rx_en;
  assign rx_push_cnt = RLW'(rx_valid && rx_en && (rx_level != RLW'(RX_DEPTH)));

  ahb_uart_bridge_fifo #(.DEPTH(TX_DEPTH), .NB(NB), .LW(TLW)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_cnt  (tx_push_cnt),
    .push_data (hwdata),
    .pop_cnt   (tx_pop_cnt),
    .peek_data (tx_peek),
    .level     (tx_level)
  );

  ahb_uart_bridge_fifo #(.DEPTH(RX_DEPTH), .NB(NB), .LW(RLW)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push_cnt  (rx_push_cnt),
    .push_data (DATA_W'(rx_data)),
    .pop_cnt   (rx_pop_cnt),
    .peek_data (rx_peek),
    .level     (rx_level)
  );

  logic unused_bits;
  assign unused_bits = ^{haddr[1:0], |(haddr >> 5), wdata[63:16], wdata[7:3], tx_peek >> 8};
endmodule

// File: tb/tb_ahb_uart_bridge.sv
// tb/tb_ahb_uart_bridge.sv - randomized self-checking bench for ahb_uart_bridge
// Expected values come from byte queues modelling the TX/RX FIFOs and the ISR flags.
`ifndef AHB_ADDR_WIDTH
`define AHB_ADDR_WIDTH 32
`endif

module tb_ahb_uart_bridge;
  localparam int DEPTH = 16;
`ifdef AHB_UART_IRQ_EN
  localparam logic [31:0] CTRL_MASK = 32'h0003_FF07;
`else
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;
`endif

  logic                       clk = 1'b0;
  logic                       rst = 1'b1;
  logic                       hsel = 1'b0;
  logic                       hwrite = 1'b0;
  logic [`AHB_ADDR_WIDTH-1:0] haddr = '0;
  logic [31:0]                hwdata = '0;
  logic                       hready, hresp;
  logic [31:0]                hrdata;
  logic                       tx_valid;
  logic [7:0]                 tx_data;
  logic                       tx_ready = 1'b0;
  logic                       rx_valid = 1'b0;
  logic [7:0]                 rx_data = '0;
  logic                       rx_ready;
`ifdef AHB_UART_IRQ_EN
  logic                       irq;
`endif

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] tx_model[$];
  logic [7:0] rx_model[$];
  logic       m_rx_en = 1'b0;
  logic       m_overrun = 1'b0;
  logic [7:0] mon_exp;

  always #5 clk = ~clk;

  ahb_uart_bridge #(.DATA_W(32), .TX_DEPTH(DEPTH), .RX_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .rst      (rst),
    .hsel     (hsel),
    .hwrite   (hwrite),
    .haddr    (haddr),
    .hwdata   (hwdata),
    .hready   (hready),
    .hresp    (hresp),
    .hrdata   (hrdata),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready)
`ifdef AHB_UART_IRQ_EN
    ,
    .irq      (irq)
`endif
  );

  // Every TX handshake must deliver the oldest byte the bus has written.
  initial forever begin
    @(negedge clk);
    #4;
    if (tx_valid && tx_ready) begin
      vectors++;
      if (tx_model.size() == 0) begin
        miscompares++;
        $display("FAIL tx_byte got=%02h required=no byte pending", tx_data);
      end else begin
        mon_exp = tx_model.pop_front();
        if (tx_data !== mon_exp) begin
          miscompares++;
          $display("FAIL tx_byte got=%02h required=%02h", tx_data, mon_exp);
        end
      end
    end
  end

  function automatic logic [31:0] status_exp();
    status_exp = {13'd0, tx_model.size() == 0, rx_model.size() == 0, tx_model.size() == DEPTH,
                  8'(rx_model.size()), 8'(tx_model.size())};
  endfunction

  task automatic bus(input logic wr, input logic [2:0] off, input logic [31:0] wd, input int budget,
                     output logic [31:0] rd, output logic err, output int lat, output logic to);
    rd = '0; err = 1'b0; lat = 0; to = 1'b1;
    @(negedge clk);
    hsel = 1'b1; hwrite = wr; haddr = '0; haddr[4:0] = {off, 2'b00}; hwdata = wd;
    for (int c = 0; c < budget; c++) begin
      @(negedge clk);
      lat++;
      if (hready) begin
        rd = hrdata; err = hresp; to = 1'b0;
        break;
      end
    end
    hsel = 1'b0;
  endtask

  task automatic wr_ctrl(input logic [31:0] v);
    logic [31:0] rd; logic err, to; int lat;
    bus(1'b1, 3'd2, v, 20, rd, err, lat, to);
    m_rx_en = v[0];
    vectors++;
    if (to || err) begin
      miscompares++;
      $display("FAIL ctrl_write got err=%0b timeout=%0b required err=0 timeout=0", err, to);
    end
  endtask

  task automatic feed_byte(input logic [7:0] b);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = b;
    if (m_rx_en) begin
      if (rx_model.size() < DEPTH) rx_model.push_back(b);
      else m_overrun = 1'b1;
    end
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drain_tx(output logic ok);
    ok = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!tx_valid) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd; logic err, to; int lat;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if ({hready, hresp, hrdata, tx_valid, tx_data, rx_ready} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got hready=%0b hresp=%0b hrdata=%08h tx_valid=%0b tx_data=%02h rx_ready=%0b required all 0",
               hready, hresp, hrdata, tx_valid, tx_data, rx_ready);
    end
`ifdef AHB_UART_IRQ_EN
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL reset_irq got=%0b required=0", irq); end
`endif
    rst = 1'b0;
    bus(1'b0, 3'd1, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (to || err || lat != 2 || rd !== 32'h0006_0000) begin
      miscompares++;
      $display("FAIL reset_status got=%08h err=%0b lat=%0d required=00060000 err=0 lat=2", rd, err, lat);
    end
    bus(1'b0, 3'd2, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (to || err || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_ctrl got=%08h err=%0b required=00000000 err=0", rd, err);
    end
    bus(1'b0, 3'd3, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (to || err || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_isr got=%08h err=%0b required=00000000 err=0", rd, err);
    end
  endtask

  task automatic test_ctrl_regs();
    logic [31:0] rd, v; logic err, to; int lat;
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      wr_ctrl(v);
      bus(1'b0, 3'd2, 32'h0, 20, rd, err, lat, to);
      vectors++;
      if (to || err || rd !== (v & CTRL_MASK)) begin
        miscompares++;
        $display("FAIL ctrl_readback got=%08h required=%08h", rd, v & CTRL_MASK);
      end
    end
    wr_ctrl(32'h0);
  endtask

  task automatic test_wide_write();
    logic [31:0] rd, w; logic err, to, ok, wd; int lat;
    wr_ctrl(32'h2);
    tx_ready = 1'b1;
    tx_model.push_back(8'h11); tx_model.push_back(8'h22);
    tx_model.push_back(8'h33); tx_model.push_back(8'h44);
    bus(1'b1, 3'd0, 32'h4433_2211, 20, rd, err, lat, to);
    vectors++;
    if (to || err || lat != 2) begin
      miscompares++;
      $display("FAIL wide_write got err=%0b lat=%0d timeout=%0b required err=0 lat=2", err, lat, to);
    end
    drain_tx(ok);
    tx_ready = 1'b0;
    bus(1'b0, 3'd1, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (!ok || rd !== status_exp() || tx_model.size() != 0) begin
      miscompares++;
      $display("FAIL wide_drain got status=%08h pending=%0d required status=%08h pending=0",
               rd, tx_model.size(), status_exp());
    end
    tx_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      w = $urandom;
      wd = 1'($urandom);
      wr_ctrl({30'd0, wd, 1'b0});
      for (int b = 0; b < (wd ? 4 : 1); b++) tx_model.push_back(w[8*b +: 8]);
      bus(1'b1, 3'd0, w, 40, rd, err, lat, to);
      vectors++;
      if (to || err) begin
        miscompares++;
        $display("FAIL rand_tx_write got err=%0b timeout=%0b required err=0 timeout=0", err, to);
      end
    end
    drain_tx(ok);
    vectors++;
    if (!ok || tx_model.size() != 0) begin
      miscompares++;
      $display("FAIL rand_tx_drain got pending=%0d required=0", tx_model.size());
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_tx_stall();
    logic [31:0] rd, w; logic err, to, ok; int lat;
    wr_ctrl(32'h0);
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      tx_model.push_back(w[7:0]);
      bus(1'b1, 3'd0, w, 20, rd, err, lat, to);
      vectors++;
      if (to || err) begin miscompares++; $display("FAIL stall_fill got err=%0b timeout=%0b required 0 0", err, to); end
    end
    bus(1'b0, 3'd1, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== status_exp()) begin
      miscompares++;
      $display("FAIL stall_full_status got=%08h required=%08h", rd, status_exp());
    end
    w = $urandom;
    tx_model.push_back(w[7:0]);
    fork
      bus(1'b1, 3'd0, w, 60, rd, err, lat, to);
      begin repeat (6) @(negedge clk); tx_ready = 1'b1; end
    join
    vectors++;
    if (to || err || lat <= 5) begin
      miscompares++;
      $display("FAIL stall_17th got err=%0b lat=%0d timeout=%0b required err=0 lat>5", err, lat, to);
    end
    drain_tx(ok);
    vectors++;
    if (!ok || tx_model.size() != 0) begin
      miscompares++;
      $display("FAIL stall_drain got pending=%0d required=0", tx_model.size());
    end
    tx_ready = 1'b0;
  endtask

  task automatic test_nonblock();
    logic [31:0] rd, w; logic err, to, ok; int lat;
    wr_ctrl(32'h4);
    tx_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      w = $urandom;
      tx_model.push_back(w[7:0]);
      bus(1'b1, 3'd0, w, 20, rd, err, lat, to);
    end
    bus(1'b1, 3'd0, $urandom, 20, rd, err, lat, to);
    vectors++;
    if (to || !err || lat != 2) begin
      miscompares++;
      $display("FAIL nonblock_write got err=%0b lat=%0d required err=1 lat=2", err, lat);
    end
    bus(1'b0, 3'd1, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd[7:0] !== 8'd16 || rd !== status_exp()) begin
      miscompares++;
      $display("FAIL nonblock_level got=%08h required=%08h", rd, status_exp());
    end
    bus(1'b0, 3'd0, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (to || !err || lat != 2) begin
      miscompares++;
      $display("FAIL nonblock_read got err=%0b lat=%0d required err=1 lat=2", err, lat);
    end
    tx_ready = 1'b1;
    drain_tx(ok);
    vectors++;
    if (!ok || tx_model.size() != 0) begin
      miscompares++;
      $display("FAIL nonblock_drain got pending=%0d required=0", tx_model.size());
    end
    tx_ready = 1'b0;
    wr_ctrl(32'h0);
  endtask

  task automatic test_rx_wide();
    logic [31:0] rd, expw; logic err, to, wd; int lat, n, k;
    wr_ctrl(32'h3);
    for (int i = 0; i < 4; i++) feed_byte(8'hA0 + 8'(i));
    bus(1'b0, 3'd0, 32'h0, 20, rd, err, lat, to);
    for (int i = 0; i < 4; i++) void'(rx_model.pop_front());
    vectors++;
    if (to || err || rd !== 32'hA3A2_A1A0) begin
      miscompares++;
      $display("FAIL rx_wide_read got=%08h err=%0b required=a3a2a1a0 err=0", rd, err);
    end
    bus(1'b0, 3'd1, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== status_exp()) begin
      miscompares++;
      $display("FAIL rx_wide_status got=%08h required=%08h", rd, status_exp());
    end
    for (int it = 0; it < 10; it++) begin
      wd = 1'($urandom);
      wr_ctrl({30'd0, wd, 1'b1});
      n = $urandom_range(1, 6);
      if (rx_model.size() + n <= DEPTH) begin
        for (int i = 0; i < n; i++) feed_byte(8'($urandom));
      end
      k = wd ? 4 : 1;
      if (rx_model.size() >= k) begin
        expw = '0;
        for (int i = 0; i < k; i++) expw[8*i +: 8] = rx_model.pop_front();
        bus(1'b0, 3'd0, 32'h0, 20, rd, err, lat, to);
        vectors++;
        if (to || err || rd !== expw) begin
          miscompares++;
          $display("FAIL rx_rand_read got=%08h err=%0b required=%08h err=0", rd, err, expw);
        end
      end
    end
    wr_ctrl(32'h1);
    while (rx_model.size() > 0) begin
      expw = {24'd0, rx_model.pop_front()};
      bus(1'b0, 3'd0, 32'h0, 20, rd, err, lat, to);
      vectors++;
      if (to || err || rd !== expw) begin
        miscompares++;
        $display("FAIL rx_drain_read got=%08h required=%08h", rd, expw);
      end
    end
  endtask

  task automatic test_overrun();
    logic [31:0] rd, expw; logic err, to; int lat;
    wr_ctrl(32'h0002_0001);
    bus(1'b0, 3'd2, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== (32'h0002_0001 & CTRL_MASK)) begin
      miscompares++;
      $display("FAIL ier_readback got=%08h required=%08h", rd, 32'h0002_0001 & CTRL_MASK);
    end
    for (int i = 0; i < DEPTH + 1; i++) feed_byte(8'($urandom));
    bus(1'b0, 3'd3, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== {30'd0, m_overrun, 1'b0} || !m_overrun) begin
      miscompares++;
      $display("FAIL overrun_isr got=%08h required=00000002", rd);
    end
`ifdef AHB_UART_IRQ_EN
    vectors++;
    if (irq !== 1'b1) begin miscompares++; $display("FAIL overrun_irq got=%0b required=1", irq); end
`endif
    bus(1'b0, 3'd1, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== status_exp()) begin
      miscompares++;
      $display("FAIL overrun_status got=%08h required=%08h", rd, status_exp());
    end
    bus(1'b1, 3'd3, 32'h2, 20, rd, err, lat, to);
    m_overrun = 1'b0;
    bus(1'b0, 3'd3, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL overrun_clear got=%08h required=00000000", rd); end
`ifdef AHB_UART_IRQ_EN
    vectors++;
    if (irq !== 1'b0) begin miscompares++; $display("FAIL overrun_irq_clear got=%0b required=0", irq); end
`endif
    wr_ctrl(32'h0002_0003);
    for (int w = 0; w < 4; w++) begin
      expw = '0;
      for (int i = 0; i < 4; i++) expw[8*i +: 8] = rx_model.pop_front();
      bus(1'b0, 3'd0, 32'h0, 20, rd, err, lat, to);
      vectors++;
      if (to || err || rd !== expw) begin
        miscompares++;
        $display("FAIL overrun_read got=%08h required=%08h", rd, expw);
      end
    end
    bus(1'b0, 3'd1, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== status_exp()) begin
      miscompares++;
      $display("FAIL overrun_dropped got=%08h required=%08h", rd, status_exp());
    end
    wr_ctrl(32'h0000_0401);
    for (int i = 0; i < 3; i++) feed_byte(8'($urandom));
    bus(1'b0, 3'd3, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL thresh_below got=%08h required=00000000", rd); end
    feed_byte(8'($urandom));
    bus(1'b0, 3'd3, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== 32'h1) begin miscompares++; $display("FAIL thresh_hit got=%08h required=00000001", rd); end
    bus(1'b1, 3'd3, 32'h1, 20, rd, err, lat, to);
    bus(1'b0, 3'd3, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== 32'h1) begin miscompares++; $display("FAIL thresh_set_wins got=%08h required=00000001", rd); end
    while (rx_model.size() > 0) begin
      expw = {24'd0, rx_model.pop_front()};
      bus(1'b0, 3'd0, 32'h0, 20, rd, err, lat, to);
      vectors++;
      if (rd !== expw) begin miscompares++; $display("FAIL thresh_read got=%08h required=%08h", rd, expw); end
    end
    bus(1'b1, 3'd3, 32'h1, 20, rd, err, lat, to);
    bus(1'b0, 3'd3, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== 32'h0) begin miscompares++; $display("FAIL thresh_clear got=%08h required=00000000", rd); end
    wr_ctrl(32'h0);
  endtask

  task automatic test_bad_addr();
    logic [31:0] rd; logic err, to; int lat;
    for (int i = 0; i < 6; i++) begin
      bus(1'($urandom), 3'($urandom_range(4, 7)), $urandom, 20, rd, err, lat, to);
      vectors++;
      if (to || !err || lat != 2) begin
        miscompares++;
        $display("FAIL bad_offset got err=%0b lat=%0d required err=1 lat=2", err, lat);
      end
    end
    bus(1'b1, 3'd1, $urandom, 20, rd, err, lat, to);
    vectors++;
    if (to || !err || lat != 2) begin
      miscompares++;
      $display("FAIL status_write got err=%0b lat=%0d required err=1 lat=2", err, lat);
    end
    bus(1'b0, 3'd1, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (rd !== status_exp()) begin
      miscompares++;
      $display("FAIL bad_no_effect got=%08h required=%08h", rd, status_exp());
    end
  endtask

  task automatic test_reset_mid_access();
    logic [31:0] rd, w; logic err, to, seen; int lat;
    wr_ctrl(32'h0);
    tx_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      w = $urandom;
      tx_model.push_back(w[7:0]);
      bus(1'b1, 3'd0, w, 20, rd, err, lat, to);
    end
    seen = 1'b0;
    @(negedge clk);
    hsel = 1'b1; hwrite = 1'b0; haddr = '0;
    repeat (4) begin @(negedge clk); if (hready) seen = 1'b1; end
    rst = 1'b1; hsel = 1'b0;
    @(negedge clk);
    if (hready) seen = 1'b1;
    rst = 1'b0;
    tx_model.delete(); rx_model.delete(); m_rx_en = 1'b0; m_overrun = 1'b0;
    repeat (3) begin @(negedge clk); if (hready) seen = 1'b1; end
    vectors++;
    if (seen || tx_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abandon got hready_seen=%0b tx_valid=%0b required 0 0", seen, tx_valid);
    end
    bus(1'b0, 3'd1, 32'h0, 20, rd, err, lat, to);
    vectors++;
    if (to || rd !== 32'h0006_0000) begin
      miscompares++;
      $display("FAIL reset_mid_status got=%08h required=00060000", rd);
    end
  endtask

  initial begin
    test_reset();
    test_ctrl_regs();
    test_wide_write();
    test_tx_stall();
    test_nonblock();
    test_rx_wide();
    test_overrun();
    test_bad_addr();
    test_reset_mid_access();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    miscompares++;
    $display("FAIL watchdog got=timeout required=completion");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $fatal(1);
  end
endmodule
